lut_layer_pipe: RTL and testbench

- Parametrised, pipelined successor to the per-neuron combinational truth-table modules in the network layers.
- Holds NUM_NEURONS independent truth tables in registers. Tables are written at runtime through a config port; nothing is baked in at generation time.
- Performs one lookup per neuron per accepted beat, with valid/ready flow control on input and output.
- Sits between layer connectivity wiring (which supplies each neuron's pre-selected FAN_IN*IN_BITS address) and the next layer.

---
 rtl/lut_layer_pipe.sv | 98 +++++++++
 tb/tb_lut_layer_pipe.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_layer_pipe.sv
// Layer of NUM_NEURONS runtime-programmable truth tables behind a two-stage
// valid/ready pipeline: S1 registers the addresses, S2 registers the lookups.
module lut_layer_pipe #(
    parameter int NUM_NEURONS = 4,
    parameter int FAN_IN      = 3,
    parameter int IN_BITS     = 2,
    parameter int OUT_BITS    = 2,
    localparam int AW    = FAN_IN * IN_BITS,
    localparam int DEPTH = 2 ** AW,
    localparam int NW    = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_NEURONS*AW-1:0]       in_addr,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
    input  logic                            cfg_we,
    input  logic [NW-1:0]                   cfg_neuron,
    input  logic [AW-1:0]                   cfg_addr,
    input  logic [OUT_BITS-1:0]             cfg_data,
    output logic [31:0]                     beat_count
);

    // Handshake: a stage advances when it is empty or the stage after it
    // advances; in_ready is therefore purely combinational from out_ready.
    // A beat moves on each edge where its producer's valid and consumer's
    // ready are both high; out_valid/out_data hold until out_ready.

    logic [OUT_BITS-1:0]             lut_q [NUM_NEURONS][DEPTH];
    logic [NUM_NEURONS*AW-1:0]       s1_addr_q;
    logic                            s1_valid_q;
    logic                            s2_valid_q;
    logic [NUM_NEURONS*OUT_BITS-1:0] out_data_q;
    logic [NUM_NEURONS*OUT_BITS-1:0] out_data_d;
    logic [31:0]                     beat_count_q;
    logic                            adv1;
    logic                            adv2;

    assign adv2       = !s2_valid_q || out_ready;
    assign adv1       = !s1_valid_q || adv2;
    assign in_ready   = adv1;
    assign out_valid  = s2_valid_q;
    assign out_data   = out_data_q;
    assign beat_count = beat_count_q;

    // Out-of-range neuron indices match no table, so those writes drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < NUM_NEURONS; n++) begin
                for (int e = 0; e < DEPTH; e++) begin
                    lut_q[n][e] <= '0;
                end
            end
        end else if (cfg_we) begin
            for (int n = 0; n < NUM_NEURONS; n++) begin
                if (cfg_neuron == NW'(n)) begin
                    lut_q[n][cfg_addr] <= cfg_data;
                end
            end
        end
    end

    // Reads the pre-edge table, so a same-cycle write is seen by later beats only.
    always_comb begin
        out_data_d = '0;
        for (int n = 0; n < NUM_NEURONS; n++) begin
            out_data_d[n*OUT_BITS +: OUT_BITS] = lut_q[n][s1_addr_q[n*AW +: AW]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_addr_q    <= '0;
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            out_data_q   <= '0;
            beat_count_q <= '0;
        end else begin
            if (adv1) begin
                s1_valid_q <= in_valid;
                s1_addr_q  <= in_addr;
            end
            if (adv2) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_data_q <= out_data_d;
                end
            end
            if (s2_valid_q && out_ready) begin
                beat_count_q <= beat_count_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_lut_layer_pipe.sv
// Bench for lut_layer_pipe with three neurons, so one neuron index is out of range.
module tb_lut_layer_pipe;

    localparam int N  = 3;
    localparam int AW = 6;
    localparam int IW = N * AW;
    localparam int OW = N * 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] in_addr = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [OW-1:0] out_data;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_neuron = '0;
    logic [AW-1:0] cfg_addr = '0;
    logic [1:0]    cfg_data = '0;
    logic [31:0]   beat_count;

    int            vectors = 0;
    int            miscompares = 0;
    logic [1:0]    model [N][64];
    logic [OW-1:0] exp_q [$];
    logic          hold_pend = 1'b0;
    logic [OW-1:0] hold_data = '0;

    always #5 clk = ~clk;

    lut_layer_pipe #(.NUM_NEURONS(N), .FAN_IN(3), .IN_BITS(2), .OUT_BITS(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cfg_we(cfg_we), .cfg_neuron(cfg_neuron), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .beat_count(beat_count)
    );

    function automatic logic [OW-1:0] exp_out(input logic [IW-1:0] a);
        logic [OW-1:0] r;
        r = '0;
        for (int n = 0; n < N; n++) r[n*2 +: 2] = model[n][a[n*AW +: AW]];
        return r;
    endfunction

    // One clock cycle: drive at negedge, sample 1 ns later, score handshakes
    // that complete on the coming posedge.
    task automatic drive_cycle(input logic iv, input logic [IW-1:0] addr, input logic ordy,
                               input logic we, input logic [1:0] nrn,
                               input logic [AW-1:0] ca, input logic [1:0] cd);
        logic          exp_rdy;
        logic [OW-1:0] e;
        @(negedge clk);
        in_valid = iv; in_addr = addr; out_ready = ordy;
        cfg_we = we; cfg_neuron = nrn; cfg_addr = ca; cfg_data = cd;
        #1;
        if (rst) begin
            exp_q.delete();
            hold_pend = 1'b0;
            for (int n = 0; n < N; n++)
                for (int a = 0; a < 64; a++) model[n][a] = 2'b00;
        end else begin
            if (hold_pend) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== hold_data) begin
                    miscompares++;
                    $display("FAIL stall_hold: got valid=%b data=%h, expected valid=1 data=%h",
                             out_valid, out_data, hold_data);
                end
            end
            exp_rdy = !(exp_q.size() == 2 && !out_ready);
            vectors++;
            if (in_ready !== exp_rdy) begin
                miscompares++;
                $display("FAIL in_ready: got %b expected %b (occupancy %0d)", in_ready, exp_rdy, exp_q.size());
            end
            if (out_valid === 1'b1 && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_beat: got data=%h expected no beat", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        miscompares++;
                        $display("FAIL out_data: got %h expected %h", out_data, e);
                    end
                end
            end
            hold_pend = (out_valid === 1'b1) && !out_ready;
            hold_data = out_data;
            if (we && nrn < N) model[nrn][ca] = cd;
            if (iv && in_ready === 1'b1) exp_q.push_back(exp_out(addr));
        end
    endtask

    task automatic idle(input logic ordy);
        drive_cycle(1'b0, '0, ordy, 1'b0, 2'd0, '0, 2'b00);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle(1'b0);
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1'b1);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: got %0d beats outstanding expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        apply_reset();
        apply_reset();
        idle(1'b1);
        vectors++;
        if (out_valid !== 1'b0 || out_data !== '0 || beat_count !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_state: got valid=%b data=%h count=%0d expected 0/0/0",
                     out_valid, out_data, beat_count);
        end
    endtask

    task automatic test_zero_stream();
        for (int c = 0; c < 8; c++) begin
            drive_cycle(1'b1, IW'($urandom), 1'b1, 1'b0, 2'd0, '0, 2'b00);
            if (c == 1) begin
                vectors++;
                if (out_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL latency_early: got out_valid=%b expected 0", out_valid);
                end
            end
            if (c == 2) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== '0) begin
                    miscompares++;
                    $display("FAIL latency_first: got valid=%b data=%h expected 1/0", out_valid, out_data);
                end
            end
            if (c >= 3) begin
                vectors++;
                if (beat_count !== 32'(c - 2)) begin
                    miscompares++;
                    $display("FAIL beat_count_stream: got %0d expected %0d", beat_count, c - 2);
                end
            end
        end
        drain();
    endtask

    task automatic test_program();
        logic [IW-1:0] a;
        logic [IW-1:0] b;
        for (int i = 0; i < 64; i++) begin
            logic [AW-1:0] ai;
            ai = AW'(i);
            drive_cycle(1'b0, '0, 1'b1, 1'b1, 2'd0, ai, ai[4] ? 2'b11 : 2'b00);
        end
        a = IW'($urandom); a[5:0] = 6'b010000;
        b = IW'($urandom); b[5:0] = 6'b101111;
        drive_cycle(1'b1, a, 1'b1, 1'b0, 2'd0, '0, 2'b00);
        drive_cycle(1'b1, b, 1'b1, 1'b0, 2'd0, '0, 2'b00);
        idle(1'b1);
        vectors++;
        if (out_valid !== 1'b1 || out_data[1:0] !== 2'b11) begin
            miscompares++;
            $display("FAIL program_first: got valid=%b n0=%b expected 1/11", out_valid, out_data[1:0]);
        end
        idle(1'b1);
        vectors++;
        if (out_valid !== 1'b1 || out_data[1:0] !== 2'b00) begin
            miscompares++;
            $display("FAIL program_second: got valid=%b n0=%b expected 1/00", out_valid, out_data[1:0]);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [IW-1:0] beats [8];
        int            sent = 0;
        int            taken = 0;
        apply_reset();
        for (int n = 0; n < N; n++)
            for (int i = 0; i < 64; i++)
                drive_cycle(1'b0, '0, 1'b1, 1'b1, 2'(n), AW'(i), 2'($urandom_range(0, 3)));
        for (int i = 0; i < 8; i++)
            for (int n = 0; n < N; n++) beats[i][n*AW +: AW] = AW'(i * 9 + n * 5 + 1);
        for (int c = 0; c < 300 && taken < 8; c++) begin
            drive_cycle(sent < 8, beats[sent < 8 ? sent : 0], 1'($urandom_range(0, 1)),
                        1'b0, 2'd0, '0, 2'b00);
            if (in_valid && in_ready === 1'b1) sent++;
            if (out_valid === 1'b1 && out_ready) taken++;
        end
        vectors++;
        if (sent != 8 || taken != 8) begin
            miscompares++;
            $display("FAIL backpressure_timeout: got sent=%0d taken=%0d expected 8/8", sent, taken);
        end
        idle(1'b0);
        vectors++;
        if (beat_count !== 32'd8) begin
            miscompares++;
            $display("FAIL backpressure_count: got %0d expected 8", beat_count);
        end
        drain();
    endtask

    task automatic test_same_cycle_write();
        logic [IW-1:0] a;
        a = '0;
        a[AW +: AW] = 6'd5;
        drive_cycle(1'b0, '0, 1'b1, 1'b1, 2'd1, 6'd5, 2'b01);
        drive_cycle(1'b1, a, 1'b1, 1'b0, 2'd0, '0, 2'b00);
        drive_cycle(1'b1, a, 1'b1, 1'b1, 2'd1, 6'd5, 2'b10);
        idle(1'b1);
        vectors++;
        if (out_valid !== 1'b1 || out_data[3:2] !== 2'b01) begin
            miscompares++;
            $display("FAIL same_cycle_old: got valid=%b n1=%b expected 1/01", out_valid, out_data[3:2]);
        end
        idle(1'b1);
        vectors++;
        if (out_valid !== 1'b1 || out_data[3:2] !== 2'b10) begin
            miscompares++;
            $display("FAIL same_cycle_new: got valid=%b n1=%b expected 1/10", out_valid, out_data[3:2]);
        end
        drain();
    endtask

    task automatic sweep_all_entries();
        for (int i = 0; i < 64; i++)
            drive_cycle(1'b1, {N{6'(i)}}, 1'b1, 1'b0, 2'd0, '0, 2'b00);
        drain();
    endtask

    task automatic test_out_of_range();
        for (int i = 0; i < 64; i++)
            drive_cycle(1'b0, '0, 1'b1, 1'b1, 2'd3, AW'(i), ~model[2][i]);
        sweep_all_entries();
    endtask

    task automatic test_reset_mid();
        drive_cycle(1'b1, IW'($urandom), 1'b0, 1'b0, 2'd0, '0, 2'b00);
        drive_cycle(1'b1, IW'($urandom), 1'b0, 1'b0, 2'd0, '0, 2'b00);
        idle(1'b0);
        apply_reset();
        idle(1'b1);
        vectors++;
        if (out_valid !== 1'b0 || beat_count !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_mid: got valid=%b count=%0d expected 0/0", out_valid, beat_count);
        end
        drive_cycle(1'b1, {N{6'h2a}}, 1'b1, 1'b0, 2'd0, '0, 2'b00);
        idle(1'b1);
        idle(1'b1);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== '0) begin
            miscompares++;
            $display("FAIL reset_fresh: got valid=%b data=%h expected 1/0", out_valid, out_data);
        end
        drain();
        sweep_all_entries();
    endtask

    initial begin
        test_reset();
        test_zero_stream();
        test_program();
        test_backpressure();
        test_same_cycle_write();
        test_out_of_range();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
